bypass_reg_file: RTL and testbench

BYPASS_REG_FILE -- requirements
Module: bypass_reg_file

---
 rtl/bypass_reg_file_pkg.sv | 23 ++
 rtl/bypass_reg_file_scoreboard.sv | 64 ++++++
 rtl/bypass_reg_file.sv | 142 ++++++++++++++
 tb/tb_bypass_reg_file.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bypass_reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bypass_reg_file_pkg
//  Description : Shared types and default sizing for the bypassing register
//                file and its pending-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package bypass_reg_file_pkg;

  // Controller states: INIT walks every register to its own index, then RUN.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Default geometry: 15 implemented 32-bit registers behind a 4-bit index,
  // so index 15 is a deliberately unimplemented hole.
  localparam int C_DATA_W   = 32;
  localparam int C_ADDR_W   = 4;
  localparam int C_NUM_REGS = 15;

endpackage
`default_nettype wire

// File: rtl/bypass_reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : One pending bit per implemented register. A lock marks a
//                register as awaiting a producer; a write-back clears it. When
//                a lock and a write hit the same register in one cycle the
//                lock wins, since it belongs to the newer producer.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic              i_lock_en,
  input  logic [ADDR_W-1:0] i_lock_dest,
  input  logic              i_wa_en,
  input  logic [ADDR_W-1:0] i_wa_dest,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_dest,
  input  logic [ADDR_W-1:0] i_src1,
  input  logic [ADDR_W-1:0] i_src2,
  output logic              o_src1_pending,
  output logic              o_src2_pending
);

  logic [NUM_REGS-1:0] r_pending;
  logic                w_p1;
  logic                w_p2;

  // Pending bit update: lock sets, write clears, lock beats write. Indices
  // outside the implemented range never match, so they are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else if (i_run) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_lock_en && (i_lock_dest == ADDR_W'(i))) begin
          r_pending[i] <= 1'b1;
        end else if ((i_wa_en && (i_wa_dest == ADDR_W'(i))) ||
                     (i_wb_en && (i_wb_dest == ADDR_W'(i)))) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Pending lookup: registered bits only, unimplemented indices read 0.
  always_comb begin
    w_p1 = 1'b0;
    w_p2 = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_src1 == ADDR_W'(i)) w_p1 = r_pending[i];
      if (i_src2 == ADDR_W'(i)) w_p2 = r_pending[i];
    end
  end

  assign o_src1_pending = w_p1;
  assign o_src2_pending = w_p2;

endmodule
`default_nettype wire

// File: rtl/bypass_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : bypass_reg_file
//  Description : Register file with two combinational read ports, two
//                write-back ports with same-cycle read forwarding (port B has
//                priority), a self-initialising INIT sequence that loads each
//                register with its own index, and a pending-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module bypass_reg_file
  import bypass_reg_file_pkg::*;
#(
  parameter int DATA_W   = C_DATA_W,
  parameter int ADDR_W   = C_ADDR_W,
  parameter int NUM_REGS = C_NUM_REGS   // must not exceed 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic [DATA_W-1:0] reg_val1,
  output logic [DATA_W-1:0] reg_val2,
  input  logic              wa_en,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wa_dest,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wa_data,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_dest,
  output logic              src1_pending,
  output logic              src2_pending,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_REGS - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_ready;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic                w_run;
  logic                w_src1_ok;
  logic                w_src2_ok;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;

  assign w_run     = (r_state == ST_RUN);
  assign w_src1_ok = (32'(src1) < 32'(NUM_REGS));
  assign w_src2_ok = (32'(src2) < 32'(NUM_REGS));

  // Controller: INIT counts through every register once, then RUN forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_cnt == c_last_idx) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage: INIT loads reg[cnt] with cnt; in RUN port B overrides port A.
  // Storage is not cleared by reset: INIT rewrites it, and until then reads
  // show whatever the previous run left behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (!w_run) begin
          if (r_cnt == ADDR_W'(i)) r_regs[i] <= DATA_W'(i);
        end else if (wb_en && (wb_dest == ADDR_W'(i))) begin
          r_regs[i] <= wb_data;
        end else if (wa_en && (wa_dest == ADDR_W'(i))) begin
          r_regs[i] <= wa_data;
        end
      end
    end
  end

  // Read ports: array lookup, then same-cycle forwarding with B over A.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (src1 == ADDR_W'(i)) w_rd1 = r_regs[i];
      if (src2 == ADDR_W'(i)) w_rd2 = r_regs[i];
    end
    if (w_run && w_src1_ok) begin
      if (wa_en && (wa_dest == src1)) w_rd1 = wa_data;
      if (wb_en && (wb_dest == src1)) w_rd1 = wb_data;
    end
    if (w_run && w_src2_ok) begin
      if (wa_en && (wa_dest == src2)) w_rd2 = wa_data;
      if (wb_en && (wb_dest == src2)) w_rd2 = wb_data;
    end
  end

  assign reg_val1 = w_rd1;
  assign reg_val2 = w_rd2;
  assign ready    = r_ready;

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .i_run          (w_run),
    .i_lock_en      (lock_en),
    .i_lock_dest    (lock_dest),
    .i_wa_en        (wa_en),
    .i_wa_dest      (wa_dest),
    .i_wb_en        (wb_en),
    .i_wb_dest      (wb_dest),
    .i_src1         (src1),
    .i_src2         (src2),
    .o_src1_pending (src1_pending),
    .o_src2_pending (src2_pending)
  );

endmodule
`default_nettype wire

// File: tb/tb_bypass_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bypass_reg_file
//  Description : Directed bench for bypass_reg_file (default geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bypass_reg_file;

  logic        clk;
  logic        rst;
  logic [3:0]  src1, src2;
  logic [31:0] reg_val1, reg_val2;
  logic        wa_en, wb_en;
  logic [3:0]  wa_dest, wb_dest;
  logic [31:0] wa_data, wb_data;
  logic        lock_en;
  logic [3:0]  lock_dest;
  logic        src1_pending, src2_pending;
  logic        ready;

  int n_pass;
  int n_total;

  typedef struct {
    logic [3:0]  s1, s2;
    logic        wae;
    logic [3:0]  wad;
    logic [31:0] wav;
    logic        wbe;
    logic [3:0]  wbd;
    logic [31:0] wbv;
    logic        lke;
    logic [3:0]  lkd;
    logic [31:0] e1, e2;
    logic        ep1, ep2;
  } vec_t;

  vec_t vecs[16];

  bypass_reg_file dut (
    .clk          (clk),
    .rst          (rst),
    .src1         (src1),
    .src2         (src2),
    .reg_val1     (reg_val1),
    .reg_val2     (reg_val2),
    .wa_en        (wa_en),
    .wb_en        (wb_en),
    .wa_dest      (wa_dest),
    .wb_dest      (wb_dest),
    .wa_data      (wa_data),
    .wb_data      (wb_data),
    .lock_en      (lock_en),
    .lock_dest    (lock_dest),
    .src1_pending (src1_pending),
    .src2_pending (src2_pending),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  function automatic vec_t mk(input int s1, input int s2,
                              input int wae, input int wad, input logic [31:0] wav,
                              input int wbe, input int wbd, input logic [31:0] wbv,
                              input int lke, input int lkd,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input int ep1, input int ep2);
    vec_t v;
    v.s1 = 4'(s1); v.s2 = 4'(s2);
    v.wae = 1'(wae); v.wad = 4'(wad); v.wav = wav;
    v.wbe = 1'(wbe); v.wbd = 4'(wbd); v.wbv = wbv;
    v.lke = 1'(lke); v.lkd = 4'(lkd);
    v.e1 = e1; v.e2 = e2; v.ep1 = 1'(ep1); v.ep2 = 1'(ep2);
    return v;
  endfunction

  task automatic idle_inputs();
    wa_en = 1'b0; wb_en = 1'b0; lock_en = 1'b0;
    wa_dest = '0; wb_dest = '0; lock_dest = '0;
    wa_data = '0; wb_data = '0;
  endtask

  // Count negedges spent with ready low; bounded so a stuck INIT still ends.
  task automatic count_init(input string name);
    int cyc;
    cyc = 0;
    while (!ready && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk(name, 32'(cyc), 32'd15);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    src1 = '0; src2 = '0;
    idle_inputs();

    //        s1 s2 wae wad wav          wbe wbd wbv   lke lkd  e1           e2           p1 p2
    vecs[0]  = mk(7, 14, 0, 0, 0,            0, 0, 0,     0, 0, 32'd7,        32'd14,       0, 0);
    vecs[1]  = mk(3, 0,  1, 3, 32'hDEADBEEF, 0, 0, 0,     0, 0, 32'hDEADBEEF, 32'd0,        0, 0);
    vecs[2]  = mk(3, 3,  0, 0, 0,            0, 0, 0,     0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vecs[3]  = mk(5, 5,  1, 5, 32'h11,       1, 5, 32'h22,0, 0, 32'h22,       32'h22,       0, 0);
    vecs[4]  = mk(5, 4,  0, 0, 0,            0, 0, 0,     0, 0, 32'h22,       32'd4,        0, 0);
    vecs[5]  = mk(9, 15, 0, 0, 0,            0, 0, 0,     1, 9, 32'd9,        32'd0,        0, 0);
    vecs[6]  = mk(9, 9,  0, 0, 0,            1, 9, 32'h99,1, 9, 32'h99,       32'h99,       1, 1);
    vecs[7]  = mk(9, 0,  1, 9, 32'h77,       0, 0, 0,     0, 0, 32'h77,       32'd0,        1, 0);
    vecs[8]  = mk(9, 0,  0, 0, 0,            0, 0, 0,     0, 0, 32'h77,       32'd0,        0, 0);
    vecs[9]  = mk(15, 0, 1, 15, 32'hFFFF,    0, 0, 0,     1, 15,32'd0,        32'd0,        0, 0);
    vecs[10] = mk(15, 0, 0, 0, 0,            0, 0, 0,     0, 0, 32'd0,        32'd0,        0, 0);
    vecs[11] = mk(2, 6,  1, 2, 32'hAAAA,     1, 6, 32'hBBBB,0,0,32'hAAAA,     32'hBBBB,     0, 0);
    vecs[12] = mk(2, 6,  0, 0, 0,            0, 0, 0,     0, 0, 32'hAAAA,     32'hBBBB,     0, 0);
    vecs[13] = mk(1, 0,  1, 1, 32'h1234,     0, 0, 0,     1, 1, 32'h1234,     32'd0,        0, 0);
    vecs[14] = mk(1, 1,  0, 0, 0,            1, 1, 32'h4321,0,0,32'h4321,     32'h4321,     1, 1);
    vecs[15] = mk(1, 14, 0, 0, 0,            0, 0, 0,     0, 0, 32'h4321,     32'd14,       0, 0);

    // Reset and initialisation length.
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_pend1", 32'(src1_pending), 32'd0);
    rst = 1'b0;
    count_init("init_len");
    chk("ready_run", 32'(ready), 32'd1);

    // Table-driven RUN vectors; each is checked in its own cycle.
    for (int k = 0; k < 16; k++) begin
      src1 = vecs[k].s1; src2 = vecs[k].s2;
      wa_en = vecs[k].wae; wa_dest = vecs[k].wad; wa_data = vecs[k].wav;
      wb_en = vecs[k].wbe; wb_dest = vecs[k].wbd; wb_data = vecs[k].wbv;
      lock_en = vecs[k].lke; lock_dest = vecs[k].lkd;
      #1;
      chk($sformatf("v%0d_val1", k), reg_val1, vecs[k].e1);
      chk($sformatf("v%0d_val2", k), reg_val2, vecs[k].e2);
      chk($sformatf("v%0d_pend1", k), 32'(src1_pending), 32'(vecs[k].ep1));
      chk($sformatf("v%0d_pend2", k), 32'(src2_pending), 32'(vecs[k].ep2));
      @(negedge clk);
    end
    idle_inputs();

    // Leave r4 pending, then reset from RUN: pending clears, ready drops,
    // storage keeps the old r3 value until INIT rewrites it.
    lock_en = 1'b1; lock_dest = 4'd4;
    @(negedge clk);
    idle_inputs();
    src1 = 4'd4;
    #1 chk("lock4_pend", 32'(src1_pending), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    src1 = 4'd4; src2 = 4'd3;
    #1;
    chk("rst_run_pend", 32'(src1_pending), 32'd0);
    chk("rst_run_ready", 32'(ready), 32'd0);
    chk("partial_r3", reg_val2, 32'hDEADBEEF);

    // Six INIT edges (cnt 0..5 written), then reset again at cnt=6.
    repeat (6) @(negedge clk);
    chk("mid_init_r3", reg_val2, 32'd3);
    chk("mid_init_ready", 32'(ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // Writes and locks during INIT must be ignored and not forwarded.
    src1 = 4'd10; src2 = 4'd15;
    wa_en = 1'b1; wa_dest = 4'd10; wa_data = 32'h5555;
    lock_en = 1'b1; lock_dest = 4'd10;
    #1;
    chk("init_nofwd", reg_val1, 32'd10);
    chk("init_r15", reg_val2, 32'd0);
    count_init("reinit_len");
    idle_inputs();
    src1 = 4'd10; src2 = 4'd7;
    #1;
    chk("after_r10", reg_val1, 32'd10);
    chk("after_r10_pend", 32'(src1_pending), 32'd0);
    chk("after_r7", reg_val2, 32'd7);
    chk("after_ready", 32'(ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
